// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: tracks in-flight register writes, decides load-use stall and registers EX forward selects
module pipe_scoreboard #(
    parameter  int REG_W     = 5,
    parameter  int DEPTH     = 4,
    parameter  int NSRC      = 2,
    parameter  int ALU_READY = 1,
    parameter  int LD_READY  = 2,
    localparam int FW_W      = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    advance,
    input  logic                    flush,
    input  logic                    issue_valid,
    input  logic                    issue_wen,
    input  logic                    issue_load,
    input  logic [REG_W-1:0]        issue_dest,
    input  logic [NSRC-1:0]         src_used,
    input  logic [NSRC*REG_W-1:0]   src_sel,
    output logic                    stall,
    output logic [NSRC*FW_W-1:0]    fwd_sel_ex,
    output logic [DEPTH-1:0]        busy,
    output logic [15:0]             stall_cnt
);
    // The WB stage only needs its valid bit: its write is never matched
    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-2:0]              wr_q, wr_d, load_q, load_d;
    logic [DEPTH-2:0][REG_W-1:0]   dest_q, dest_d;
    logic [NSRC*FW_W-1:0]          fwd_q, fwd_d, code;
    logic [NSRC-1:0]               haz;
    logic [15:0]                   cnt_q, cnt_d;
    logic                          issue;

    assign stall      = issue_valid & |haz;
    assign issue      = issue_valid & ~stall;
    assign busy       = valid_q;
    assign fwd_sel_ex = fwd_q;
    assign stall_cnt  = cnt_q;

    // Per source: scan oldest to youngest so the youngest matching producer wins
    always_comb begin
        code = '0;
        haz  = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int s = DEPTH - 2; s >= 0; s--) begin
                if (src_used[i] && wr_q[s] && dest_q[s] == src_sel[i*REG_W +: REG_W]) begin
                    haz[i] = (s + 1) < (load_q[s] ? LD_READY : ALU_READY);
                    code[i*FW_W +: FW_W] = haz[i] ? '0 : FW_W'(s + 1);
                end
            end
        end
    end

    // Next state: advance shifts the pipe, flush then bubbles the killed slots
    always_comb begin
        valid_d = valid_q;
        wr_d    = wr_q;
        load_d  = load_q;
        dest_d  = dest_q;
        fwd_d   = fwd_q;
        cnt_d   = (advance && stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        if (advance) begin
            valid_d = {valid_q[DEPTH-2:0], issue};
            wr_d    = {wr_q[DEPTH-3:0], issue & issue_wen & |issue_dest};
            load_d  = {load_q[DEPTH-3:0], issue & issue_load};
            dest_d  = {dest_q[DEPTH-3:0], issue_dest};
            fwd_d   = issue ? code : '0;
        end
        if (flush) begin
            valid_d[0] = 1'b0;
            wr_d[0]    = 1'b0;
            fwd_d      = '0;
            if (advance) begin
                valid_d[1] = 1'b0;
                wr_d[1]    = 1'b0;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            wr_q    <= '0;
            load_q  <= '0;
            dest_q  <= '0;
            fwd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            load_q  <= load_d;
            dest_q  <= dest_d;
            fwd_q   <= fwd_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed and random checks of pipe_scoreboard against a queue-based pipeline model
module tb_pipe_scoreboard;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        advance = 0, flush = 0, issue_valid = 0, issue_wen = 0, issue_load = 0;
    logic [4:0]  issue_dest = '0;
    logic [1:0]  src_used = '0;
    logic [9:0]  src_sel = '0;
    logic        stall;
    logic [3:0]  fwd_sel_ex, busy;
    logic [15:0] stall_cnt;
    int          tests_run = 0, fails = 0;

    typedef struct packed {logic v; logic wr; logic ld; logic [4:0] d;} ent_t;
    localparam ent_t BUB = '0;
    ent_t        pipe[$];
    logic [3:0]  e_fwd;
    int          e_cnt;
    bit          est;
    logic [3:0]  ec;

    pipe_scoreboard dut (
        .CLK(CLK), .RST(RST), .advance(advance), .flush(flush), .issue_valid(issue_valid),
        .issue_wen(issue_wen), .issue_load(issue_load), .issue_dest(issue_dest),
        .src_used(src_used), .src_sel(src_sel), .stall(stall), .fwd_sel_ex(fwd_sel_ex),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    function automatic void m_eval(output bit st, output logic [3:0] codes);
        int need;
        st = 0;
        codes = '0;
        for (int i = 0; i < 2; i++) begin
            if (!src_used[i]) continue;
            for (int s = 0; s < 3; s++) begin
                if (pipe[s].wr && pipe[s].d == src_sel[i*5 +: 5]) begin
                    need = pipe[s].ld ? 2 : 1;
                    if (s + 1 < need) st = 1;
                    else codes[i*2 +: 2] = 2'(s + 1);
                    break;
                end
            end
        end
        st = st & issue_valid;
    endfunction

    function automatic logic [3:0] m_busy();
        logic [3:0] b;
        for (int s = 0; s < 4; s++) b[s] = pipe[s].v;
        return b;
    endfunction

    task automatic m_reset();
        pipe = {BUB, BUB, BUB, BUB};
        e_fwd = '0;
        e_cnt = 0;
    endtask

    task automatic drive(input bit a, f, v, w, l, input logic [4:0] d, input logic [1:0] u,
                         input logic [4:0] s0, s1);
        advance = a; flush = f; issue_valid = v; issue_wen = w; issue_load = l;
        issue_dest = d; src_used = u; src_sel = {s1, s0};
        #1;
    endtask

    task automatic step();
        bit st;
        logic [3:0] c;
        ent_t n;
        m_eval(st, c);
        if (advance && st && e_cnt < 65535) e_cnt++;
        if (advance) begin
            n = BUB;
            if (issue_valid && !st && !flush) begin
                n.v = 1; n.wr = issue_wen && issue_dest != 0; n.ld = issue_load; n.d = issue_dest;
            end
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
        if (flush) begin
            pipe[0] = BUB;
            if (advance) pipe[1] = BUB;
            e_fwd = '0;
        end else if (advance) e_fwd = (issue_valid && !st) ? c : '0;
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RST = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #2;
        RST = 0;
        m_reset();
        #1;
    endtask

    task automatic test_reset();
        RST = 1;
        drive(1, 0, 1, 1, 1, 5, 2'b11, 5, 5);
        @(posedge CLK);
        #2;
        tests_run++;
        if ({stall, busy, fwd_sel_ex, stall_cnt} !== 25'd0) begin
            fails++;
            $display("FAIL reset: got stall=%b busy=%b fwd=%h cnt=%0d, want all zero", stall, busy, fwd_sel_ex, stall_cnt);
        end
    endtask

    task automatic test_alu_raw();
        do_reset();
        drive(1, 0, 1, 1, 0, 3, 2'b00, 0, 0);
        step();
        drive(1, 0, 1, 0, 0, 0, 2'b01, 3, 0);
        tests_run++;
        if (stall !== 1'b0) begin fails++; $display("FAIL alu_raw_stall: got %b want 0", stall); end
        step();
        tests_run++;
        if (fwd_sel_ex[1:0] !== 2'd1) begin fails++; $display("FAIL alu_raw_fwd: got %0d want 1", fwd_sel_ex[1:0]); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 1, 1, 1, 5, 2'b00, 0, 0);
        step();
        drive(1, 0, 1, 0, 0, 0, 2'b10, 0, 5);
        tests_run++;
        if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall: got %b want 1", stall); end
        step();
        tests_run++;
        if (stall_cnt !== 16'd1 || busy !== 4'b0010) begin
            fails++;
            $display("FAIL load_use_state: got cnt=%0d busy=%b want cnt=1 busy=0010", stall_cnt, busy);
        end
        tests_run++;
        if (stall !== 1'b0) begin fails++; $display("FAIL load_use_release: got %b want 0", stall); end
        step();
        tests_run++;
        if (fwd_sel_ex[3:2] !== 2'd2) begin fails++; $display("FAIL load_use_fwd: got %0d want 2", fwd_sel_ex[3:2]); end
    endtask

    task automatic test_youngest();
        do_reset();
        drive(1, 0, 1, 1, 0, 3, 2'b00, 0, 0);
        step();
        step();
        drive(1, 0, 1, 0, 0, 0, 2'b01, 3, 0);
        step();
        tests_run++;
        if (fwd_sel_ex[1:0] !== 2'd1) begin fails++; $display("FAIL youngest: got %0d want 1", fwd_sel_ex[1:0]); end
        drive(1, 0, 1, 0, 0, 0, 2'b00, 3, 3);
        step();
        tests_run++;
        if (fwd_sel_ex !== 4'h0) begin fails++; $display("FAIL unused_src: got %h want 0", fwd_sel_ex); end
        drive(1, 0, 1, 1, 0, 0, 2'b00, 0, 0);
        step();
        drive(1, 0, 1, 0, 0, 0, 2'b11, 0, 0);
        step();
        tests_run++;
        if (fwd_sel_ex !== 4'h0) begin fails++; $display("FAIL r0_src: got %h want 0", fwd_sel_ex); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 1, 1, 1, 5, 2'b00, 0, 0);
        step();
        drive(1, 1, 1, 1, 0, 6, 2'b00, 0, 0);
        step();
        tests_run++;
        if (busy !== 4'b0000) begin fails++; $display("FAIL flush_busy: got %b want 0000", busy); end
        drive(1, 0, 1, 0, 0, 0, 2'b01, 5, 0);
        tests_run++;
        if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b want 0", stall); end
        step();
        tests_run++;
        if (fwd_sel_ex !== 4'h0) begin fails++; $display("FAIL flush_fwd: got %h want 0", fwd_sel_ex); end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1, 0, 1, 1, 1, 5, 2'b00, 0, 0);
        step();
        drive(0, 0, 1, 0, 0, 0, 2'b01, 5, 0);
        repeat (3) step();
        tests_run++;
        if ({stall, busy, fwd_sel_ex, stall_cnt} !== {1'b1, 4'b0001, 4'h0, 16'd0}) begin
            fails++;
            $display("FAIL hold: got stall=%b busy=%b fwd=%h cnt=%0d want 1 0001 0 0", stall, busy, fwd_sel_ex, stall_cnt);
        end
        advance = 1;
        #1;
        step();
        tests_run++;
        if (stall_cnt !== 16'd1) begin fails++; $display("FAIL hold_count: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1, 0, 1, 1, 0, 7, 2'b00, 0, 0);
        repeat (3) step();
        RST = 1;
        #1;
        tests_run++;
        if ({busy, fwd_sel_ex, stall_cnt} !== 24'd0) begin
            fails++;
            $display("FAIL mid_reset: got busy=%b fwd=%h cnt=%0d want zero", busy, fwd_sel_ex, stall_cnt);
        end
        m_reset();
        @(posedge CLK);
        #2;
        RST = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 4)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)));
            m_eval(est, ec);
            tests_run++;
            if ({stall, busy, fwd_sel_ex, stall_cnt} !== {est, m_busy(), e_fwd, e_cnt[15:0]}) begin
                fails++;
                $display("FAIL random[%0d]: got stall=%b busy=%b fwd=%h cnt=%0d want stall=%b busy=%b fwd=%h cnt=%0d",
                         n, stall, busy, fwd_sel_ex, stall_cnt, est, m_busy(), e_fwd, e_cnt);
            end
            step();
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        m_reset();
        test_reset();
        test_alu_raw();
        test_load_use();
        test_youngest();
        test_flush();
        test_hold();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
